// File: rtl/tty_tx_sched_pkg.sv
// -----------------------------------------------------------------------------
// tty_sched_pkg
// Shared definitions for the teletype transmit scheduler slice:
//   - state_t      : scheduler FSM encoding (IDLE=0, CLR=1, SET=2, WAIT=3)
//   - SRC_CPU/ECHO : source index constants (CPU DATAO = 0, echo/debug = 1)
//   - TIMEOUT_W_DEF: default width of the WAIT watchdog counter
//   - onehot_to_src: converts a two-way one-hot grant into a source index
// -----------------------------------------------------------------------------
package tty_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_SET  = 2'd2,
      ST_WAIT = 2'd3
   } state_t;

   localparam logic SRC_CPU  = 1'b0;
   localparam logic SRC_ECHO = 1'b1;

   localparam int TIMEOUT_W_DEF = 20;

   // Only bit 1 distinguishes the echo source; an all-zero grant maps to CPU.
   function automatic logic onehot_to_src(input logic [1:0] oh);
      return oh[1];
   endfunction

endpackage

// File: rtl/tty_tx_sched_if.sv
// -----------------------------------------------------------------------------
// tty_tx_sched_if
// Bundles the two character-source handshakes, the tto transmitter controls
// and the scheduler status lines.
//   master modport : source/transmitter side (drives valid, data, tto_done,
//                    timeout_clr; observes ready, pulses, tto_iob, status)
//   slave modport  : scheduler side (the reverse directions)
// -----------------------------------------------------------------------------
interface tty_tx_sched_if;

   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_ready;
   logic       tto_data_clr;
   logic       tto_data_set;
   logic [7:0] tto_iob;
   logic       tto_done;
   logic       busy;
   logic       grant;
   logic       timeout;
   logic       timeout_clr;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, tto_done, timeout_clr,
      input  req0_ready, req1_ready, tto_data_clr, tto_data_set, tto_iob,
             busy, grant, timeout
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, tto_done, timeout_clr,
      output req0_ready, req1_ready, tto_data_clr, tto_data_set, tto_iob,
             busy, grant, timeout
   );

endinterface

// File: rtl/tty_tx_sched_arb2.sv
// -----------------------------------------------------------------------------
// tty_arb2
// Two-way arbiter between the CPU and echo character sources.
//   valid0/valid1 : source requests
//   en            : arbitration allowed this cycle (scheduler idle)
//   last          : source that won the previous contention
//   gnt[1:0]      : one-hot grant (bit 0 = CPU, bit 1 = echo), zero if none
// Build option TTY_SCHED_RR_EN: defined selects round-robin on contention
// (the source other than `last` wins); undefined selects fixed priority with
// the CPU source always winning and `last` ignored.
// -----------------------------------------------------------------------------
module tty_arb2
   import tty_sched_pkg::*;
(
   input  logic       valid0,
   input  logic       valid1,
   input  logic       en,
   input  logic       last,
   output logic [1:0] gnt
);

   // Grant selection: single requester always wins, contention by policy.
   always_comb begin
      gnt = 2'b00;
      if (!en) begin
         gnt = 2'b00;
      end else if (valid0 && valid1) begin
`ifdef TTY_SCHED_RR_EN
         if (last == SRC_CPU) begin
            gnt = 2'b10;
         end else begin
            gnt = 2'b01;
         end
`else
         gnt = 2'b01;
`endif
      end else if (valid0) begin
         gnt = 2'b01;
      end else if (valid1) begin
         gnt = 2'b10;
      end else begin
         gnt = 2'b00;
      end
   end

`ifndef TTY_SCHED_RR_EN
   // Fixed priority has no use for the history input.
   logic unused_last;
   assign unused_last = last;
`endif

endmodule

// File: rtl/tty_tx_sched.sv
// -----------------------------------------------------------------------------
// tty_tx_sched
// Shares the single tto transmitter between the CPU DATAO source (0) and the
// echo/debug source (1). A character is accepted with a one-cycle ready
// strobe, latched onto tto_iob, followed by a clr pulse then a set pulse, and
// the scheduler then waits for a rising edge of tto_done (or a watchdog
// expiry) before accepting the next character.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus (slave) : req0/req1 valid/data/ready, tto_data_clr/set, tto_iob,
//                 tto_done, busy, grant, timeout, timeout_clr
// Parameter TIMEOUT_W: watchdog width; expiry after 2^TIMEOUT_W-1 WAIT cycles.
// Build option TTY_SCHED_RR_EN: round-robin on contention (else CPU first).
// -----------------------------------------------------------------------------
module tty_tx_sched
   import tty_sched_pkg::*;
#(
   parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
   input  logic          clk,
   input  logic          reset,
   tty_tx_sched_if.slave bus
);

   localparam logic [TIMEOUT_W-1:0] WDOG_ZERO = {TIMEOUT_W{1'b0}};
   localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

   state_t               state_r;
   state_t               next_state_s;
   logic [1:0]           gnt_s;
   logic                 arb_en_s;
   logic                 accept_s;
   logic                 last_s;
   logic                 done_edge_s;
   logic                 wdog_expire_s;
   logic [TIMEOUT_W-1:0] wdog_r;
   logic [TIMEOUT_W-1:0] wdog_inc_s;
   logic                 done_q_r;
   logic                 clr_r;
   logic                 set_r;
   logic                 busy_r;
   logic                 grant_r;
   logic                 timeout_r;
   logic [7:0]           iob_r;

`ifdef TTY_SCHED_RR_EN
   logic                 last_r;
   logic                 contend_s;

   assign contend_s = bus.req0_valid & bus.req1_valid;
   assign last_s    = last_r;
`else
   assign last_s    = SRC_ECHO;
`endif

   // Arbitration only happens while idle, so ready can never fire elsewhere.
   assign arb_en_s = (state_r == ST_IDLE);

   tty_arb2 u_arb (
      .valid0 (bus.req0_valid),
      .valid1 (bus.req1_valid),
      .en     (arb_en_s),
      .last   (last_s),
      .gnt    (gnt_s)
   );

   assign accept_s = |gnt_s;

   // Completion is a rising edge of the done level while waiting; done_q
   // tracks the level from CLR onwards so a done that is still high from the
   // previous frame cannot be mistaken for completion.
   assign done_edge_s = (state_r == ST_WAIT) & bus.tto_done & ~done_q_r;

   // Expiry is flagged on the cycle the counter would step to all-ones; a
   // done edge in the same cycle takes precedence.
   assign wdog_inc_s    = wdog_r + WDOG_ONE;
   assign wdog_expire_s = (state_r == ST_WAIT) & ~done_edge_s & (&wdog_inc_s);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               next_state_s = ST_CLR;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_CLR:  next_state_s = ST_SET;
         ST_SET:  next_state_s = ST_WAIT;
         ST_WAIT: begin
            if (done_edge_s || wdog_expire_s) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Registered pulse and busy outputs, decoded from the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         clr_r  <= 1'b0;
         set_r  <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         clr_r  <= (next_state_s == ST_CLR);
         set_r  <= (next_state_s == ST_SET);
         busy_r <= (next_state_s != ST_IDLE);
      end
   end

   // Character and source capture on accept; held through the transmission.
   always_ff @(posedge clk) begin
      if (reset) begin
         iob_r   <= 8'h00;
         grant_r <= SRC_CPU;
      end else if (accept_s) begin
         iob_r   <= gnt_s[1] ? bus.req1_data : bus.req0_data;
         grant_r <= onehot_to_src(gnt_s);
      end else begin
         iob_r   <= iob_r;
         grant_r <= grant_r;
      end
   end

   // Done-level history: cleared while idle, follows tto_done from CLR on.
   always_ff @(posedge clk) begin
      if (reset) begin
         done_q_r <= 1'b0;
      end else if (state_r == ST_IDLE) begin
         done_q_r <= 1'b0;
      end else begin
         done_q_r <= bus.tto_done;
      end
   end

   // Watchdog counter: zeroed by the set pulse, counts WAIT cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_r <= WDOG_ZERO;
      end else if (state_r == ST_SET) begin
         wdog_r <= WDOG_ZERO;
      end else if (state_r == ST_WAIT) begin
         wdog_r <= wdog_inc_s;
      end else begin
         wdog_r <= wdog_r;
      end
   end

   // Sticky timeout flag; a new expiry wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_r <= 1'b0;
      end else if (wdog_expire_s) begin
         timeout_r <= 1'b1;
      end else if (bus.timeout_clr) begin
         timeout_r <= 1'b0;
      end else begin
         timeout_r <= timeout_r;
      end
   end

`ifdef TTY_SCHED_RR_EN
   // Round-robin history: only contended grants move the pointer, so the
   // first contention after reset goes to the CPU source.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_r <= SRC_ECHO;
      end else if (accept_s && contend_s) begin
         last_r <= onehot_to_src(gnt_s);
      end else begin
         last_r <= last_r;
      end
   end
`endif

   assign bus.req0_ready   = gnt_s[0];
   assign bus.req1_ready   = gnt_s[1];
   assign bus.tto_data_clr = clr_r;
   assign bus.tto_data_set = set_r;
   assign bus.tto_iob      = iob_r;
   assign bus.busy         = busy_r;
   assign bus.grant        = grant_r;
   assign bus.timeout      = timeout_r;

endmodule
